ftdi_fifo_responder: RTL

Synthesizable device-side model of the FTDI asynchronous 245-FIFO interface. It drives txe/rxf (active-low) and serves ftdi_rd/ftdi_wr strobes from an FPGA-side FTDI host controller. It is used for on-chip loopback and for bench bring-up of the LaserDrop host path without a physical FTDI part. Bytes destined for the host arrive on an inject stream. Bytes written by the host leave on a capture stream.

---
 rtl/ftdi_fifo_responder.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ftdi_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module   : ftdi_fifo_responder
// Brief    : Device-side model of an FTDI async 245-FIFO; inject stream feeds
//            host reads, host writes leave on the capture stream.
// Revision : 1.0
// ============================================================================
module ftdi_fifo_responder #(
    parameter int DEPTH         = 16,
    parameter int RXF_PRECHARGE = 2,
    parameter int TXE_PRECHARGE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        ftdi_rd,
    input  logic        ftdi_wr,
    input  logic        adbus_tri,
    input  logic [7:0]  adbus_in,
    output logic        rxf,
    output logic        txe,
    output logic [7:0]  adbus_out,
    output logic        adbus_drive,
    input  logic        inject_valid,
    input  logic [7:0]  inject_data,
    output logic        inject_ready,
    output logic        capture_valid,
    output logic [7:0]  capture_data,
    input  logic        capture_ready,
    output logic        rd_err,
    output logic        wr_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int            c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);
    localparam logic [7:0]    c_RXF_PRE = 8'(RXF_PRECHARGE);
    localparam logic [7:0]    c_TXE_PRE = 8'(TXE_PRECHARGE);

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_ACTIVE = 2'd1,
        R_PRE    = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_ACTIVE = 2'd1,
        W_PRE    = 2'd2
    } wr_state_t;

    rd_state_t     r_rd_state, w_rd_state_nxt;
    wr_state_t     r_wr_state, w_wr_state_nxt;
    logic [7:0]    r_rd_pre, w_rd_pre_nxt;
    logic [7:0]    r_wr_pre, w_wr_pre_nxt;
    logic          r_rd_q, r_wr_q;
    logic [7:0]    r_hold;
    logic          r_bad, w_bad_nxt;
    logic          r_rd_err, r_wr_err;
    logic [15:0]   r_rd_count, r_wr_count;
    logic [c_AW:0] r_inj_wp, r_inj_rp, r_cap_wp, r_cap_rp;
    logic [7:0]    r_inj_mem [DEPTH];
    logic [7:0]    r_cap_mem [DEPTH];

    logic [c_AW:0] w_inj_lvl, w_cap_lvl;
    logic          w_inj_empty, w_inj_full, w_cap_empty, w_cap_full;
    logic          w_inj_push, w_inj_pop, w_cap_push, w_cap_pop;
    logic          w_both, w_rd_rise, w_wr_rise;
    logic          w_rxf_fsm, w_txe_fsm, w_drive_fsm, w_latch;
    logic          w_rd_err_set, w_wr_err_set;

    // DEPTH is a power of two, so the level MSB alone marks "full"
    assign w_inj_lvl   = r_inj_wp - r_inj_rp;
    assign w_cap_lvl   = r_cap_wp - r_cap_rp;
    assign w_inj_empty = (w_inj_lvl == '0);
    assign w_inj_full  = w_inj_lvl[c_AW];
    assign w_cap_empty = (w_cap_lvl == '0);
    assign w_cap_full  = w_cap_lvl[c_AW];

    assign w_both    = !ftdi_rd && !ftdi_wr;
    assign w_rd_rise = ftdi_rd && !r_rd_q;
    assign w_wr_rise = ftdi_wr && !r_wr_q;

    assign w_inj_push = inject_valid && !w_inj_full;
    assign w_cap_pop  = !w_cap_empty && capture_ready;

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_pre_nxt   = r_rd_pre;
        w_rxf_fsm      = 1'b1;
        w_drive_fsm    = 1'b0;
        w_inj_pop      = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                w_rxf_fsm   = w_inj_empty;
                w_drive_fsm = !ftdi_rd && !w_inj_empty;
                if (!ftdi_rd && !w_inj_empty && !w_both)
                    w_rd_state_nxt = R_ACTIVE;
            end
            R_ACTIVE: begin
                w_rxf_fsm   = 1'b0;
                w_drive_fsm = !ftdi_rd;
                if (w_rd_rise) begin
                    w_inj_pop      = 1'b1;
                    w_rd_pre_nxt   = c_RXF_PRE;
                    w_rd_state_nxt = R_PRE;
                end
            end
            R_PRE: begin
                w_rd_pre_nxt = r_rd_pre - 8'd1;
                if (r_rd_pre <= 8'd1)
                    w_rd_state_nxt = R_IDLE;
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_pre_nxt   = r_wr_pre;
        w_txe_fsm      = 1'b1;
        w_latch        = 1'b0;
        w_cap_push     = 1'b0;
        w_bad_nxt      = r_bad;
        case (r_wr_state)
            W_IDLE: begin
                w_txe_fsm = w_cap_full;
                if (!ftdi_wr && !w_cap_full && !w_both) begin
                    w_wr_state_nxt = W_ACTIVE;
                    w_latch        = 1'b1;
                    w_bad_nxt      = !adbus_tri;
                end
            end
            W_ACTIVE: begin
                w_txe_fsm = 1'b0;
                if (!ftdi_wr) begin
                    w_latch = !w_both;
                    if (!adbus_tri)
                        w_bad_nxt = 1'b1;
                end else if (w_wr_rise) begin
                    // A transfer that saw an undriven bus is dropped silently
                    w_cap_push     = !r_bad;
                    w_wr_pre_nxt   = c_TXE_PRE;
                    w_wr_state_nxt = W_PRE;
                end
            end
            W_PRE: begin
                w_wr_pre_nxt = r_wr_pre - 8'd1;
                if (r_wr_pre <= 8'd1)
                    w_wr_state_nxt = W_IDLE;
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    assign w_rd_err_set = (!ftdi_rd && w_rxf_fsm) || w_both || (w_drive_fsm && adbus_tri);
    assign w_wr_err_set = (!ftdi_wr && w_txe_fsm) || w_both ||
                          (!ftdi_wr && !adbus_tri &&
                           (r_wr_state == W_IDLE || r_wr_state == W_ACTIVE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_state <= R_IDLE;
            r_wr_state <= W_IDLE;
            r_rd_pre   <= 8'd0;
            r_wr_pre   <= 8'd0;
            r_rd_q     <= 1'b1;
            r_wr_q     <= 1'b1;
            r_hold     <= 8'd0;
            r_bad      <= 1'b0;
            r_rd_err   <= 1'b0;
            r_wr_err   <= 1'b0;
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
            r_inj_wp   <= '0;
            r_inj_rp   <= '0;
            r_cap_wp   <= '0;
            r_cap_rp   <= '0;
        end else if (clear) begin
            r_rd_state <= R_IDLE;
            r_wr_state <= W_IDLE;
            r_rd_pre   <= 8'd0;
            r_wr_pre   <= 8'd0;
            r_rd_q     <= 1'b1;
            r_wr_q     <= 1'b1;
            r_hold     <= 8'd0;
            r_bad      <= 1'b0;
            r_rd_err   <= 1'b0;
            r_wr_err   <= 1'b0;
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
            r_inj_wp   <= '0;
            r_inj_rp   <= '0;
            r_cap_wp   <= '0;
            r_cap_rp   <= '0;
        end else begin
            r_rd_q     <= ftdi_rd;
            r_wr_q     <= ftdi_wr;
            r_rd_state <= w_rd_state_nxt;
            r_wr_state <= w_wr_state_nxt;
            r_rd_pre   <= w_rd_pre_nxt;
            r_wr_pre   <= w_wr_pre_nxt;
            r_bad      <= w_bad_nxt;
            if (w_latch)
                r_hold <= adbus_in;
            if (w_rd_err_set)
                r_rd_err <= 1'b1;
            if (w_wr_err_set)
                r_wr_err <= 1'b1;
            if (w_inj_push)
                r_inj_wp <= r_inj_wp + c_PTR_ONE;
            if (w_inj_pop) begin
                r_inj_rp   <= r_inj_rp + c_PTR_ONE;
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_cap_push) begin
                r_cap_wp   <= r_cap_wp + c_PTR_ONE;
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_cap_pop)
                r_cap_rp <= r_cap_rp + c_PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (w_inj_push)
            r_inj_mem[r_inj_wp[c_AW-1:0]] <= inject_data;
        if (w_cap_push)
            r_cap_mem[r_cap_wp[c_AW-1:0]] <= r_hold;
    end

    // Handshake outputs are forced idle for as long as reset or clear is held
    assign rxf           = reset || clear || w_rxf_fsm;
    assign txe           = reset || clear || w_txe_fsm;
    assign adbus_drive   = !reset && !clear && w_drive_fsm;
    assign adbus_out     = w_inj_empty ? 8'h00 : r_inj_mem[r_inj_rp[c_AW-1:0]];
    assign inject_ready  = !w_inj_full;
    assign capture_valid = !w_cap_empty;
    assign capture_data  = w_cap_empty ? 8'h00 : r_cap_mem[r_cap_rp[c_AW-1:0]];
    assign rd_err        = r_rd_err;
    assign wr_err        = r_wr_err;
    assign rd_count      = r_rd_count;
    assign wr_count      = r_wr_count;

endmodule
`default_nettype wire
